// File: rtl/alu_norte_branch_adder.sv
// Branch-target adder for the MIPS datapath: registers pc + offset
// together with unsigned carry and signed overflow for the PC-source mux.
module alu_norte_branch_adder #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned OFFSET_SHIFT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] sinal_shift,
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] saida_mux,
    output logic             out_valid,
    output logic             carry_out,
    output logic             overflow
);

    logic [WIDTH-1:0] off;
    logic [WIDTH:0]   sum;
    logic             ovf_raw;

    logic [WIDTH-1:0] saida_mux_d, saida_mux_q;
    logic             out_valid_d, out_valid_q;
    logic             carry_out_d, carry_out_q;
    logic             overflow_d,  overflow_q;

    // Offset alignment, widened add and signed-overflow detection.
    always_comb begin
        off     = sinal_shift << OFFSET_SHIFT;
        sum     = {1'b0, pc} + {1'b0, off};
        ovf_raw = (pc[WIDTH-1] == off[WIDTH-1]) && (sum[WIDTH-1] != pc[WIDTH-1]);
    end

    // Next-state: capture on in_valid, otherwise hold; operands are only
    // selected when in_valid is high so idle-cycle garbage never reaches state.
    always_comb begin
        saida_mux_d = saida_mux_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            saida_mux_d = sum[WIDTH-1:0];
            carry_out_d = sum[WIDTH];
            overflow_d  = ovf_raw;
            out_valid_d = 1'b1;
        end
    end

    // Result registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            saida_mux_q <= '0;
            out_valid_q <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            saida_mux_q <= saida_mux_d;
            out_valid_q <= out_valid_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign saida_mux = saida_mux_q;
    assign out_valid = out_valid_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_norte_branch_adder.sv
// Self-checking bench for alu_norte_branch_adder (default 32-bit, no extra shift).
module tb_alu_norte_branch_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] sinal_shift;
    logic [31:0] pc;
    logic [31:0] saida_mux;
    logic        out_valid;
    logic        carry_out;
    logic        overflow;

    int tests_run = 0;
    int tests_failed = 0;
    bit cmp_en = 1'b1;

    alu_norte_branch_adder #(
        .WIDTH(32),
        .OFFSET_SHIFT(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .sinal_shift(sinal_shift),
        .pc(pc),
        .saida_mux(saida_mux),
        .out_valid(out_valid),
        .carry_out(carry_out),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain 64-bit arithmetic on the captured operands.
    logic [31:0] m_mux;
    logic        m_valid, m_carry, m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mux = 0; m_valid = 0; m_carry = 0; m_ovf = 0;
        end else if (in_valid) begin
            longint unsigned usum;
            longint          ssum;
            usum    = longint'({32'b0, pc}) + longint'({32'b0, sinal_shift});
            ssum    = longint'($signed(pc)) + longint'($signed(sinal_shift));
            m_mux   = usum[31:0];
            m_carry = usum >= 64'h1_0000_0000;
            m_ovf   = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
            m_valid = 1;
        end else begin
            m_valid = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_lit(input string name, input logic [31:0] mux, input logic v,
                             input logic c, input logic o);
        check({name, ".mux"}, saida_mux, mux);
        check({name, ".valid"}, {31'b0, out_valid}, {31'b0, v});
        check({name, ".carry"}, {31'b0, carry_out}, {31'b0, c});
        check({name, ".ovf"}, {31'b0, overflow}, {31'b0, o});
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model.mux", saida_mux, m_mux);
            check("model.valid", {31'b0, out_valid}, {31'b0, m_valid});
            check("model.carry", {31'b0, carry_out}, {31'b0, m_carry});
            check("model.ovf", {31'b0, overflow}, {31'b0, m_ovf});
        end
    end

    task automatic drive(input logic [31:0] p, input logic [31:0] s, input logic v);
        pc = p; sinal_shift = s; in_valid = v;
    endtask

    // Present operands, then sample just after the capturing edge.
    task automatic step(input logic [31:0] p, input logic [31:0] s, input logic v);
        drive(p, s, v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(32'h55, 32'h10, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
            check_lit("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;

        step(32'd0, 32'd0, 1'b1);
        check_lit("add0", 32'd0, 1'b1, 1'b0, 1'b0);
        step(32'd0, 32'd10, 1'b1);
        check_lit("add10", 32'd10, 1'b1, 1'b0, 1'b0);
        step(32'd10, 32'd10, 1'b1);
        check_lit("add20", 32'd20, 1'b1, 1'b0, 1'b0);

        step(32'd99, 32'd1, 1'b0);
        check_lit("hold", 32'd20, 1'b0, 1'b0, 1'b0);
        step(32'd12345, 32'd777, 1'b0);
        check_lit("hold2", 32'd20, 1'b0, 1'b0, 1'b0);
        step(32'd99, 32'd1, 1'b1);
        check_lit("resume", 32'd100, 1'b1, 1'b0, 1'b0);

        step(32'h0000_0100, 32'hFFFF_FFF0, 1'b1);
        check_lit("neg", 32'h0000_00F0, 1'b1, 1'b1, 1'b0);
        step(32'h7FFF_FFFC, 32'd8, 1'b1);
        check_lit("ovf", 32'h8000_0004, 1'b1, 1'b0, 1'b1);
        step(32'hFFFF_FFFC, 32'd8, 1'b1);
        check_lit("wrap", 32'h0000_0004, 1'b1, 1'b1, 1'b0);
        step(32'h8000_0000, 32'h8000_0000, 1'b1);
        check_lit("negovf", 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        step(32'h0, 32'h0, 1'b0);
        check_lit("holdflags", 32'h0, 1'b0, 1'b1, 1'b1);

        // Back-to-back accepts
        step(32'h1000, 32'hFFFF_FFFC, 1'b1);
        check_lit("b2b_a", 32'h0FFC, 1'b1, 1'b1, 1'b0);
        step(32'h2000, 32'h0000_0040, 1'b1);
        check_lit("b2b_b", 32'h2040, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset between edges while a result is valid
        step(32'h3000, 32'h4, 1'b1);
        check_lit("pre_rst", 32'h3004, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_lit("async_rst", 32'h0, 1'b0, 1'b0, 1'b0);
        drive(32'd4, 32'd4, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 check_lit("post_rst", 32'd8, 1'b1, 1'b0, 1'b0);

        step(32'd4, 32'd4, 1'b0);
        check_lit("post_rst_hold", 32'd8, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        #1 cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_norte_branch_adder.md
Name: alu_norte_branch_adder

Overview:
- Branch-target adder ("north ALU") of the MIPS datapath.
- Adds the program counter to the sign-extended, pre-shifted branch offset.
- Presents the target, registered, to the PC-source multiplexer.
- Also reports carry and signed overflow for debug and exception logic.

Parameters:
- WIDTH, 32, datapath width of pc, sinal_shift and saida_mux.
- OFFSET_SHIFT, 0, extra left shift applied internally to sinal_shift before the add. 0 means the input is already shifted by 2 upstream.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid this cycle; result captured when high.
- sinal_shift  input  WIDTH  branch offset, two's complement, already sign-extended and shifted.
- pc  input  WIDTH  current program counter (normally PC+4).
- saida_mux  output  WIDTH  registered branch target = pc + (sinal_shift << OFFSET_SHIFT).
- out_valid  output  1  high for the cycle after an accepted in_valid.
- carry_out  output  1  unsigned carry out of the MSB of the registered sum.
- overflow  output  1  signed overflow of the registered sum.

Behaviour:
- Reset
  - rst_n low asynchronously forces saida_mux=0, out_valid=0, carry_out=0, overflow=0, regardless of clk.
  - Outputs stay at these values while rst_n is low.
  - The first capture can occur on the first rising edge after rst_n deasserts.
- Datapath
  - off = sinal_shift << OFFSET_SHIFT, truncated to WIDTH.
  - sum = pc + off, computed in WIDTH+1 bits.
- Capture
  - On a rising clk edge with in_valid=1: saida_mux <= sum[WIDTH-1:0]; carry_out <= sum[WIDTH].
  - overflow <= (pc[MSB]==off[MSB]) && (sum[WIDTH-1]!=pc[MSB]).
  - out_valid <= 1.
- Hold
  - On a rising edge with in_valid=0: saida_mux, carry_out and overflow hold their values; out_valid <= 0.
- Latency: exactly 1 clock from operand presentation to saida_mux/out_valid. No backpressure, so a new operand pair can be accepted every cycle.
- Wrap-around: the sum is modulo 2^WIDTH. For example, pc=0xFFFFFFFC with offset 8 gives 0x00000004 with carry_out=1 and overflow=0.
- Negative offsets: backward branches use two's complement.
  - pc=0x100, offset=0xFFFFFFF0 gives 0xF0, carry_out=1, overflow=0.
- Operand changes while in_valid=0 have no effect on the outputs.
- Reset mid-operation: if rst_n falls in the same cycle as an in_valid pulse, that operand is discarded and the outputs read the reset values. No partial result is ever visible.
- X/Z on operands while in_valid=0 must not propagate to the outputs.
- Purely synchronous core apart from the reset. No latches, and no combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst_n=0 with pc=0x55, sinal_shift=0x10, in_valid=1 -> saida_mux=0, out_valid=0, carry_out=0, overflow=0 throughout.
- Basic add sequence:
  - pc=0, sinal_shift=0, in_valid=1 -> saida_mux=0 next edge.
  - then sinal_shift=10 -> saida_mux=10.
  - then pc=10 -> saida_mux=20, with out_valid=1 each cycle.
- Negative offset: pc=0x00000100, sinal_shift=0xFFFFFFF0 -> saida_mux=0x000000F0, carry_out=1, overflow=0.
- Overflow and wrap:
  - pc=0x7FFFFFFC, sinal_shift=8 -> saida_mux=0x80000004, overflow=1, carry_out=0.
  - pc=0xFFFFFFFC, sinal_shift=8 -> saida_mux=0x00000004, carry_out=1, overflow=0.
- Hold: after a result of 20, drop in_valid and change pc=99, sinal_shift=1 -> saida_mux stays 20, out_valid=0. Reasserting in_valid gives 100 one cycle later.
- Async reset mid-stream: pulse rst_n low between clock edges while out_valid=1 -> outputs clear immediately without waiting for clk. After release, a fresh pc=4, sinal_shift=4 yields saida_mux=8.
